// File: rtl/jpeg_pkg.sv
// Shared JPEG constants: coefficient width, block size and the zigzag scan table.
// No logic, so no latency or backpressure of its own.
// Also used by the inverse scan stage, which walks the same table the other way.
package jpeg_pkg;

  localparam int COEF_W   = 11;
  localparam int BLK_SIZE = 64;
  localparam int IDX_W    = 6;

  // Zigzag position -> raster position inside an 8x8 block.
  localparam logic [5:0] ZZ [BLK_SIZE] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  // Raster address of the coefficient emitted at zigzag position idx.
  function automatic logic [5:0] zz_addr(input logic [5:0] idx);
    return ZZ[idx];
  endfunction

endpackage

// File: rtl/coef_bank.sv
// One 8x8 coefficient bank: simple dual-port RAM, one write port, one registered read port.
// Latency: read data appears one clock after re_i; write visible to reads on the next clock.
// Backpressure: the read register holds its value while re_i is low.
module coef_bank #(
  parameter int W     = 11,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  // Storage array: never reset, a block is always fully written before it is read.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register: doubles as the output data register of the buffer, so it resets to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/zigzag_buffer.sv
// Raster-to-zigzag reorder of 8x8 quantized coefficient blocks using two ping-pong banks.
// Latency: first zigzag output valid one clock after the 64th raster input is accepted.
// Backpressure: rdy_out drops while both banks hold unissued blocks; out/last hold while !rdy_in.
module zigzag_buffer #(
  parameter int COEF_W   = jpeg_pkg::COEF_W,
  parameter int BLK_SIZE = jpeg_pkg::BLK_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena_in,
  output logic              rdy_out,
  input  logic [COEF_W-1:0] in,
  output logic              ena_out,
  input  logic              rdy_in,
  output logic [COEF_W-1:0] out,
  output logic              last
);

  localparam int IDX_W = jpeg_pkg::IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_SIZE - 1);

  // Write side state
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic             wr_bank_q, wr_bank_d;
  // Bank occupancy: set when a block is completely written, cleared when its last entry is issued
  logic [1:0]       full_q, full_d;
  // Read side state
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic             rd_bank_q, rd_bank_d;
  // Output register state; the data itself lives in the bank read registers
  logic             vld_q, vld_d;
  logic             last_q, last_d;
  logic             sel_q, sel_d;

  logic             wr_fire;
  logic             rd_load;
  logic [1:0]       bank_we;
  logic [1:0]       bank_re;
  logic [IDX_W-1:0] rd_addr;
  logic [COEF_W-1:0] bank_rdata [2];

  assign rdy_out = ~full_q[wr_bank_q];
  assign wr_fire = ena_in & rdy_out;
  // The output register refills when it is empty or being consumed this edge.
  assign rd_load = (~vld_q | rdy_in) & full_q[rd_bank_q];
  assign rd_addr = jpeg_pkg::zz_addr(rd_idx_q);

  assign bank_we = {wr_fire & wr_bank_q, wr_fire & ~wr_bank_q};
  assign bank_re = {rd_load & rd_bank_q, rd_load & ~rd_bank_q};

  // Next-state for both counters, bank pointers, full flags and output flags.
  always_comb begin
    wr_idx_d  = wr_idx_q;
    wr_bank_d = wr_bank_q;
    full_d    = full_q;
    rd_idx_d  = rd_idx_q;
    rd_bank_d = rd_bank_q;
    vld_d     = vld_q;
    last_d    = last_q;
    sel_d     = sel_q;

    if (wr_fire) begin
      if (wr_idx_q == LAST_IDX) begin
        wr_idx_d          = '0;
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wr_idx_d = wr_idx_q + IDX_W'(1);
      end
    end

    // Set and clear always target different banks: a write needs the bank empty, an issue needs it full.
    if (rd_load) begin
      vld_d  = 1'b1;
      last_d = (rd_idx_q == LAST_IDX);
      sel_d  = rd_bank_q;
      if (rd_idx_q == LAST_IDX) begin
        rd_idx_d          = '0;
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end else begin
        rd_idx_d = rd_idx_q + IDX_W'(1);
      end
    end else if (rdy_in) begin
      vld_d  = 1'b0;
      last_d = 1'b0;
    end
  end

  // State registers; reset discards any partial or complete block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx_q  <= '0;
      wr_bank_q <= 1'b0;
      full_q    <= 2'b00;
      rd_idx_q  <= '0;
      rd_bank_q <= 1'b0;
      vld_q     <= 1'b0;
      last_q    <= 1'b0;
      sel_q     <= 1'b0;
    end else begin
      wr_idx_q  <= wr_idx_d;
      wr_bank_q <= wr_bank_d;
      full_q    <= full_d;
      rd_idx_q  <= rd_idx_d;
      rd_bank_q <= rd_bank_d;
      vld_q     <= vld_d;
      last_q    <= last_d;
      sel_q     <= sel_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    coef_bank #(
      .W     (COEF_W),
      .DEPTH (BLK_SIZE),
      .AW    (IDX_W)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .we_i    (bank_we[b]),
      .waddr_i (wr_idx_q),
      .wdata_i (in),
      .re_i    (bank_re[b]),
      .raddr_i (rd_addr),
      .rdata_o (bank_rdata[b])
    );
  end

  // Only the bank that was last read updates its read register, so the selected word stays put under backpressure.
  assign out     = bank_rdata[sel_q];
  assign ena_out = vld_q;
  assign last    = last_q;

endmodule

// File: tb/tb_zigzag_buffer.sv
// Self-checking bench for zigzag_buffer: directed block sequences plus randomized handshakes.
// Inputs driven and outputs sampled on the falling edge; transfers happen on the following rising edge.
// A queue-based reference reorders each completed 64-entry block with a diagonal-walk zigzag order.
module tb_zigzag_buffer;

  localparam int W = 11;

  logic         clk = 1'b0;
  logic         rst;
  logic         ena_in;
  logic         rdy_out;
  logic [W-1:0] in_dat;
  logic         ena_out;
  logic         rdy_in;
  logic [W-1:0] out_dat;
  logic         last;

  zigzag_buffer #(.COEF_W(W), .BLK_SIZE(64)) dut (
    .clk     (clk),
    .rst     (rst),
    .ena_in  (ena_in),
    .rdy_out (rdy_out),
    .in      (in_dat),
    .ena_out (ena_out),
    .rdy_in  (rdy_in),
    .out     (out_dat),
    .last    (last)
  );

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] v; logic l; } exp_t;
  typedef struct { int k; int exp_out; logic exp_last; } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int zz_ref [64];
  logic [W-1:0] blk_q [$];
  exp_t         exp_q [$];
  logic [W-1:0] cap_q [$];
  logic         capl_q [$];
  int blk_done_cyc, first_vld_cyc, first_xfer_cyc, last_xfer_cyc;
  logic         prev_stall;
  logic [W-1:0] prev_out;
  logic         prev_last;
  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Zigzag order from first principles: walk anti-diagonals, alternating direction.
  function automatic void build_zz();
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo;
      int hi;
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz_ref[k] = r * 8 + (s - r); k++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz_ref[k] = r * 8 + (s - r); k++; end
      end
    end
  endfunction

  task automatic step(input logic e, input logic [W-1:0] d, input logic r, output logic acc);
    exp_t x;
    ena_in = e;
    in_dat = d;
    rdy_in = r;
    if (ena_out === 1'b1 && first_vld_cyc < 0) first_vld_cyc = cyc;
    if (prev_stall) begin
      chk("hold_vld", ena_out, 1);
      chk("hold_out", out_dat, prev_out);
      chk("hold_last", last, prev_last);
    end
    prev_stall = ena_out && !r;
    prev_out   = out_dat;
    prev_last  = last;
    acc = e && rdy_out;
    if (acc) begin
      blk_q.push_back(d);
      if (blk_q.size() == 64) begin
        for (int k = 0; k < 64; k++) begin
          x.v = blk_q[zz_ref[k]];
          x.l = (k == 63);
          exp_q.push_back(x);
        end
        blk_q.delete();
        blk_done_cyc = cyc;
      end
    end
    if (ena_out && r) begin
      cap_q.push_back(out_dat);
      capl_q.push_back(last);
      if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
      last_xfer_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_out: got %0d expected no output", out_dat);
      end else begin
        x = exp_q.pop_front();
        chk("out_val", out_dat, x.v);
        chk("out_last", last, x.l);
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic feed(input logic [W-1:0] d, input logic r, output int steps);
    logic a = 1'b0;
    steps = 0;
    while (!a && steps < 200) begin
      step(1'b1, d, r, a);
      steps++;
    end
    if (!a) begin
      checks++;
      errors++;
      $display("FAIL feed_timeout: got no accept expected accept within 200 cycles");
    end
  endtask

  task automatic drain(input int bound);
    logic a;
    int n = 0;
    while (exp_q.size() > 0 && n < bound) begin
      step(1'b0, '0, 1'b1, a);
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic clear_cap();
    cap_q.delete();
    capl_q.delete();
    first_vld_cyc  = -1;
    first_xfer_cyc = -1;
    last_xfer_cyc  = -1;
  endtask

  initial begin
    int s;
    int tot;
    int acc;
    int n;
    logic a;

    tbl[0]  = '{0, 0, 1'b0};
    tbl[1]  = '{1, 1, 1'b0};
    tbl[2]  = '{2, 8, 1'b0};
    tbl[3]  = '{3, 16, 1'b0};
    tbl[4]  = '{4, 9, 1'b0};
    tbl[5]  = '{5, 2, 1'b0};
    tbl[6]  = '{9, 24, 1'b0};
    tbl[7]  = '{20, 40, 1'b0};
    tbl[8]  = '{36, 57, 1'b0};
    tbl[9]  = '{62, 62, 1'b0};
    tbl[10] = '{63, 63, 1'b1};

    build_zz();
    prev_stall = 1'b0;
    prev_out   = '0;
    prev_last  = 1'b0;
    blk_done_cyc = -1;
    clear_cap();

    // Reset state
    rst = 1'b1; ena_in = 1'b0; in_dat = '0; rdy_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ena_out", ena_out, 0);
    chk("rst_last", last, 0);
    chk("rst_out", out_dat, 0);
    chk("rst_rdy_out", rdy_out, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy_out", rdy_out, 1);

    // Single block, raster values 0..63
    clear_cap();
    tot = 0;
    for (int i = 0; i < 64; i++) begin feed(W'(i), 1'b1, s); tot += s; end
    chk("t1_no_stall", tot, 64);
    drain(200);
    chk("t1_latency", first_vld_cyc - blk_done_cyc, 2);
    chk("t1_count", cap_q.size(), 64);
    if (cap_q.size() == 64) begin
      for (int i = 0; i < 11; i++) begin
        chk($sformatf("t1_vec_out_%0d", tbl[i].k), cap_q[tbl[i].k], tbl[i].exp_out);
        chk($sformatf("t1_vec_last_%0d", tbl[i].k), capl_q[tbl[i].k], tbl[i].exp_last);
      end
    end

    // Back-to-back blocks: no bubble at the bank swap, rdy_out stays high
    clear_cap();
    tot = 0;
    for (int i = 0; i < 128; i++) begin
      feed((i < 64) ? W'(i) : W'(100 + i - 64), 1'b1, s);
      tot += s;
    end
    chk("t2_rdy_out_high", tot, 128);
    drain(300);
    chk("t2_count", cap_q.size(), 128);
    chk("t2_no_gap", last_xfer_cyc - first_xfer_cyc, 127);
    if (cap_q.size() == 128) begin
      chk("t2_blk2_zz0", cap_q[64], 100);
      chk("t2_blk2_zz2", cap_q[66], 108);
      chk("t2_blk2_zz63", cap_q[127], 163);
    end

    // Backpressure: three blocks offered with downstream stalled
    clear_cap();
    acc = 0;
    for (int i = 0; i < 200; i++) begin
      step(1'b1, W'(200 + acc), 1'b0, a);
      if (a) acc++;
    end
    chk("t3_accepts", acc, 128);
    chk("t3_rdy_out_low", rdy_out, 0);
    chk("t3_ena_out", ena_out, 1);
    chk("t3_out_zz0", out_dat, 200);
    n = 0;
    while (acc < 192 && n < 2000) begin
      step(1'b1, W'(200 + acc), 1'b1, a);
      if (a) acc++;
      n++;
    end
    chk("t3_all_accepted", acc, 192);
    drain(400);
    chk("t3_count", cap_q.size(), 192);

    // Random handshakes over 20 blocks
    acc = 0;
    n = 0;
    while (acc < 1280 && n < 20000) begin
      step(1'($urandom % 2), W'($urandom), 1'($urandom % 2), a);
      if (a) acc++;
      n++;
    end
    chk("t4_accepts", acc, 1280);
    drain(5000);
    chk("t4_no_partial", blk_q.size(), 0);

    // Reset mid-stream: block 1 half drained, block 2 at raster index 30
    for (int i = 0; i < 64; i++) feed(W'(300 + i), 1'b0, s);
    for (int i = 0; i < 30; i++) feed(W'(400 + i), 1'b1, s);
    chk("t5_pre_vld", ena_out, 1);
    ena_in = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_ena_out", ena_out, 0);
    chk("t5_rst_rdy_out", rdy_out, 1);
    chk("t5_rst_last", last, 0);
    exp_q.delete();
    blk_q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_cap();
    for (int i = 0; i < 64; i++) feed(W'(500 + i), 1'b1, s);
    drain(200);
    chk("t5_count", cap_q.size(), 64);
    if (cap_q.size() == 64) begin
      chk("t5_zz0", cap_q[0], 500);
      chk("t5_zz2", cap_q[2], 508);
      chk("t5_zz63_last", capl_q[63], 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
